fp_align_shifter: RTL and testbench



---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_sticky_rshift.sv | 25 ++
 rtl/fp_align_shifter.sv | 161 ++++++++++++++++
 tb/tb_fp_align_shifter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the FP adder significand alignment stage.
package fp_pkg;

    localparam int FP_EXP_W     = 11;
    localparam int FP_MANT_W    = 53;
    localparam int FP_GRS_W     = 3;
    localparam int FP_SAT_LIMIT = FP_MANT_W + FP_GRS_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_sticky_rshift.sv
// Combinational right shift by amt (0..W) that folds every shifted-out bit into the LSB as sticky.
module fp_sticky_rshift #(
    parameter int W  = 56,
    parameter int SW = 6
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] amt,
    output logic [W-1:0]  dout
);

    logic [W-1:0] shifted;
    logic         lost;

    always_comb begin
        shifted = din >> amt;
        lost    = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(amt)) begin
                lost = lost | din[i];
            end
        end
        dout = {shifted[W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/fp_align_shifter.sv
// Significand alignment: picks the larger-exponent operand and right-shifts the other with G/R/S.
// Define FP_ALIGN_BARREL_EN for a single-cycle full barrel shift instead of STEP bits per cycle.
module fp_align_shifter
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int STEP   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W-1:0]           exp_a,
    input  logic [EXP_W-1:0]           exp_b,
    input  logic [MANT_W-1:0]          mant_a,
    input  logic [MANT_W-1:0]          mant_b,
    input  logic [EXP_W-1:0]           diff,
    input  logic                       slt,
    input  logic                       ovfl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W-1:0]           exp_out,
    output logic [MANT_W-1:0]          big_mant,
    output logic [MANT_W+FP_GRS_W-1:0] small_aligned,
    output logic                       swapped
);

    localparam int AW    = MANT_W + FP_GRS_W;
    localparam int REM_W = $clog2(AW + 1);
    localparam logic [REM_W-1:0] SAT_R = REM_W'(AW);
    localparam logic [EXP_W-1:0] SAT_E = EXP_W'(AW);

    // Handshake: a transfer happens on any edge where valid and ready are both high;
    // the result is held unchanged from out_valid rising until out_valid & out_ready.
    align_state_t state_q, state_d;

    logic              accept;
    logic [MANT_W-1:0] small_sel, big_sel;
    logic [EXP_W-1:0]  exp_sel;
    logic [REM_W-1:0]  rem_init;
    logic [AW-1:0]     w_q, sh_in, sh_out;
    logic [REM_W-1:0]  sh_amt;
    logic              start_shift, shift_last;

    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] big_q;
    logic              swapped_q;

    assign accept = in_valid && (state_q == ST_IDLE);

    always_comb begin
        small_sel = slt ? mant_a : mant_b;
        big_sel   = slt ? mant_b : mant_a;
        exp_sel   = slt ? exp_b  : exp_a;
        if (ovfl || (diff > SAT_E)) begin
            rem_init = SAT_R;
        end else begin
            rem_init = diff[REM_W-1:0];
        end
    end

`ifdef FP_ALIGN_BARREL_EN
    assign sh_in       = {small_sel, {FP_GRS_W{1'b0}}};
    assign sh_amt      = rem_init;
    assign start_shift = 1'b0;
    assign shift_last  = 1'b1;
`else
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    logic [REM_W-1:0] rem_q, step_amt, rem_left;

    assign step_amt    = (rem_q < STEP_R) ? rem_q : STEP_R;
    assign rem_left    = rem_q - step_amt;
    assign sh_in       = w_q;
    assign sh_amt      = step_amt;
    assign start_shift = (rem_init != '0);
    assign shift_last  = (rem_left == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= rem_init;
        end else if (state_q == ST_SHIFT) begin
            rem_q <= rem_left;
        end
    end
`endif

    fp_sticky_rshift #(
        .W  (AW),
        .SW (REM_W)
    ) u_shift (
        .din  (sh_in),
        .amt  (sh_amt),
        .dout (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (shift_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Operands are captured only on accept, so port changes later have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= '0;
            big_q     <= '0;
            swapped_q <= 1'b0;
            w_q       <= '0;
        end else if (accept) begin
            exp_q     <= exp_sel;
            big_q     <= big_sel;
            swapped_q <= slt;
`ifdef FP_ALIGN_BARREL_EN
            w_q       <= sh_out;
`else
            w_q       <= {small_sel, {FP_GRS_W{1'b0}}};
`endif
        end else if (state_q == ST_SHIFT) begin
            w_q <= sh_out;
        end
    end

    assign exp_out       = exp_q;
    assign big_mant      = big_q;
    assign small_aligned = w_q;
    assign swapped       = swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Randomized and directed bench for fp_align_shifter against an arithmetic alignment model.
module tb_fp_align_shifter;

    localparam int EXP_W  = 11;
    localparam int MANT_W = 53;
    localparam int AW     = MANT_W + 3;
    localparam int STEP   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp_a, exp_b, diff;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              slt, ovfl;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-1:0] big_mant;
    logic [AW-1:0]     small_aligned;
    logic              swapped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_align_shifter #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .STEP   (STEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .exp_a         (exp_a),
        .exp_b         (exp_b),
        .mant_a        (mant_a),
        .mant_b        (mant_b),
        .diff          (diff),
        .slt           (slt),
        .ovfl          (ovfl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .exp_out       (exp_out),
        .big_mant      (big_mant),
        .small_aligned (small_aligned),
        .swapped       (swapped)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_shift(input logic [EXP_W-1:0] d, input logic ov);
        if (ov || int'(d) > AW) return AW;
        return int'(d);
    endfunction

    // Exact right shift of {m,000} by sh with all lost bits ORed into bit 0.
    function automatic logic [AW-1:0] model_align(input logic [MANT_W-1:0] m, input int sh);
        logic [AW-1:0] w;
        logic [AW-1:0] res;
        logic [AW-1:0] mask;
        w = {m, 3'b000};
        if (sh >= AW) begin
            res = '0;
            res[0] = (w != '0);
            return res;
        end
        res  = w >> sh;
        mask = (AW'(1) << sh) - AW'(1);
        if ((w & mask) != '0) res[0] = 1'b1;
        return res;
    endfunction

    function automatic int model_latency(input int sh);
`ifdef FP_ALIGN_BARREL_EN
        return 1;
`else
        return 1 + (sh + STEP - 1) / STEP;
`endif
    endfunction

    task automatic scramble_inputs();
        exp_a  = EXP_W'($urandom());
        exp_b  = EXP_W'($urandom());
        mant_a = MANT_W'({$urandom(), $urandom()});
        mant_b = MANT_W'({$urandom(), $urandom()});
        diff   = EXP_W'($urandom());
        slt    = 1'($urandom());
        ovfl   = 1'($urandom());
    endtask

    task automatic drive_op(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb,
                            input logic [MANT_W-1:0] ma, input logic [MANT_W-1:0] mb,
                            input logic [EXP_W-1:0] d, input logic s, input logic ov);
        exp_a    = ea;
        exp_b    = eb;
        mant_a   = ma;
        mant_b   = mb;
        diff     = d;
        slt      = s;
        ovfl     = ov;
        in_valid = 1'b1;
    endtask

    task automatic run_op(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb,
                          input logic [MANT_W-1:0] ma, input logic [MANT_W-1:0] mb,
                          input logic [EXP_W-1:0] d, input logic s, input logic ov,
                          input int hold);
        logic [AW-1:0]     e_small;
        logic [MANT_W-1:0] e_big;
        logic [EXP_W-1:0]  e_exp;
        int                sh;
        int                lat;
        sh      = model_shift(d, ov);
        e_small = model_align(s ? ma : mb, sh);
        e_big   = s ? mb : ma;
        e_exp   = s ? eb : ea;

        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        drive_op(ea, eb, ma, mb, d, s, ov);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                scramble_inputs();
            end
        end while (!out_valid && lat < 64);

        check("latency", lat, model_latency(sh));
        check("small_aligned", small_aligned, e_small);
        check("big_mant", big_mant, e_big);
        check("exp_out", exp_out, e_exp);
        check("swapped", swapped, s);

        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_small", small_aligned, e_small);
            check("hold_exp", exp_out, e_exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_after_take", out_valid, 0);
        check("in_ready_after_take", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0;
        diff  = '0; slt = 1'b0; ovfl = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_small", small_aligned, 0);
        check("rst_big", big_mant, 0);
        check("rst_exp", exp_out, 0);
        check("rst_swapped", swapped, 0);
        rst = 1'b0;

        run_op(11'd1023, 11'd1023, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 11'd0, 1'b0, 1'b0, 0);
        run_op(11'd1023, 11'd1021, 53'h10_0000_0000_0000, 53'h10_0000_0000_0001, 11'd2, 1'b0, 1'b0, 0);
        run_op(11'd1023, 11'd1019, 53'h10_0000_0000_0000, 53'h10_0000_0000_0001, 11'd4, 1'b0, 1'b0, 0);
        run_op(11'd1080, 11'd1100, 53'h1F_FFFF_FFFF_FFFF, 53'h15_5555_5555_5555, 11'd20, 1'b1, 1'b0, 2);
        run_op(11'd1500, 11'd1300, 53'h12_3456_789A_BCDE, 53'h10_0000_0000_0001, 11'd200, 1'b0, 1'b0, 0);
        run_op(11'd100, 11'd2000, 53'h10_0000_0000_0001, 53'h1A_BCDE_F012_3456, 11'd3, 1'b1, 1'b1, 0);
        run_op(11'd1500, 11'd1300, 53'h12_3456_789A_BCDE, 53'h0, 11'd200, 1'b0, 1'b0, 0);
        run_op(11'd900, 11'd891, 53'h1C_0000_0000_0000, 53'h1F_0F0F_0F0F_0F0F, 11'd9, 1'b0, 1'b0, 5);
        run_op(11'd900, 11'd844, 53'h1C_0000_0000_0000, 53'h10_0000_0000_0000, 11'd56, 1'b0, 1'b0, 0);
        run_op(11'd900, 11'd845, 53'h1C_0000_0000_0000, 53'h1F_FFFF_FFFF_FFFF, 11'd55, 1'b0, 1'b0, 0);
        run_op(11'd843, 11'd900, 53'h10_0000_0000_0000, 53'h1C_0000_0000_0000, 11'd57, 1'b1, 1'b0, 0);

        // Abandon an in-flight operation with reset.
        @(negedge clk);
        drive_op(11'd1000, 11'd960, 53'h1A_AAAA_AAAA_AAAA, 53'h15_5555_5555_5555, 11'd40, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_small", small_aligned, 0);
        check("midrst_big", big_mant, 0);
        check("midrst_exp", exp_out, 0);
        check("midrst_swapped", swapped, 0);
        rst = 1'b0;
        run_op(11'd700, 11'd700, 53'h13_3333_3333_3333, 53'h17_7777_7777_7777, 11'd0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [EXP_W-1:0]  ea, eb, d;
            logic [MANT_W-1:0] ma, mb;
            logic              s, ov;
            ea = EXP_W'($urandom_range(100, 1900));
            s  = 1'($urandom());
            ov = ($urandom_range(0, 9) == 0);
            d  = EXP_W'($urandom_range(0, 70));
            eb = s ? ea + d : ea - d;
            ma = MANT_W'({$urandom(), $urandom()});
            mb = MANT_W'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) begin
                ma[MANT_W-1] = 1'b1;
                mb[MANT_W-1] = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                if (s) ma = '0;
                else mb = '0;
            end
            run_op(ea, eb, ma, mb, d, s, ov, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
